// File: rtl/branch_pred_table.sv
// Direct-mapped branch prediction table with per-entry tag, saturating counter and target,
// cleared by a sequential invalidate walk. Optional gshare indexing via `BRANCH_PRED_GSHARE_EN.
module branch_pred_table #(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int TAG_W   = 8,
    parameter int WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              clear,
    output logic              ready,
    input  logic [WORD_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [WORD_W-1:0] pred_target,
    input  logic              upd_en,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [WORD_W-1:0] upd_target
);

    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int TAG_LSB = IDX_W + 2;
    localparam int TAG_MSB = IDX_W + 1 + TAG_W;

    localparam logic [CTR_W-1:0] CTR_WNT  = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT   = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        INIT,
        READY
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   walk_idx_q;
    logic               ready_q;

    logic               valid_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [CTR_W-1:0]   ctr_q   [ENTRIES];
    logic [WORD_W-1:0]  tgt_q   [ENTRIES];

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               upd_accept;
    logic               upd_hit;

    logic               upd_we;
    logic               upd_valid_d;
    logic [TAG_W-1:0]   upd_tag_d;
    logic [CTR_W-1:0]   upd_ctr_d;
    logic [WORD_W-1:0]  upd_tgt_d;

    logic               unused_pc_bits;

    assign lk_tag = lookup_pc[TAG_MSB:TAG_LSB];
    assign up_tag = upd_pc[TAG_MSB:TAG_LSB];

    assign unused_pc_bits = ^{lookup_pc[1:0], lookup_pc[WORD_W-1:TAG_MSB+1],
                              upd_pc[1:0], upd_pc[WORD_W-1:TAG_MSB+1]};

`ifdef BRANCH_PRED_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    assign lk_idx = lookup_pc[IDX_W+1:2] ^ ghr_q;
    assign up_idx = upd_pc[IDX_W+1:2] ^ ghr_q;

    // Lookups and updates in the same cycle both see the pre-shift history.
    always_ff @(posedge CLK) begin
        if (!nRST || clear) begin
            ghr_q <= '0;
        end else if (upd_accept) begin
            ghr_q <= {ghr_q[IDX_W-2:0], upd_taken};
        end
    end
`else
    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign up_idx = upd_pc[IDX_W+1:2];
`endif

    assign upd_accept = nRST & ready_q & upd_en;
    assign upd_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        upd_we      = 1'b0;
        upd_valid_d = valid_q[up_idx];
        upd_tag_d   = tag_q[up_idx];
        upd_ctr_d   = ctr_q[up_idx];
        upd_tgt_d   = tgt_q[up_idx];
        if (upd_accept) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (upd_taken) begin
                    upd_ctr_d = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : ctr_q[up_idx] + 1'b1;
                    upd_tgt_d = upd_target;
                end else begin
                    upd_ctr_d = (ctr_q[up_idx] == CTR_ZERO) ? CTR_ZERO : ctr_q[up_idx] - 1'b1;
                end
            end else if (upd_taken) begin
                upd_we      = 1'b1;
                upd_valid_d = 1'b1;
                upd_tag_d   = up_tag;
                upd_ctr_d   = CTR_WT;
                upd_tgt_d   = upd_target;
            end
        end
    end

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST || clear) begin
            state_q    <= INIT;
            walk_idx_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    walk_idx_q <= walk_idx_q + 1'b1;
                    if (walk_idx_q == IDX_LAST) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q    <= INIT;
                    walk_idx_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the table has no reset; the invalidate walk clears it so it can map to plain RAM.
    always_ff @(posedge CLK) begin
        if (nRST && state_q == INIT) begin
            valid_q[walk_idx_q] <= 1'b0;
            ctr_q[walk_idx_q]   <= CTR_WNT;
        end else if (upd_we) begin
            valid_q[up_idx] <= upd_valid_d;
            tag_q[up_idx]   <= upd_tag_d;
            ctr_q[up_idx]   <= upd_ctr_d;
            tgt_q[up_idx]   <= upd_tgt_d;
        end
    end

    // Lookup reads registered contents only; a same-cycle update is not bypassed.
    assign ready       = ready_q;
    assign pred_hit    = ready_q && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
    assign pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + WORD_W'(4);

endmodule
